// File: rtl/plcp_frame_parser_if.sv
`default_nettype none
//==============================================================================
// Interface : plcp_frame_parser_if
// Decoded-bit input, descrambled PSDU output and header/status for the parser.
// Rev       : 1.0
//==============================================================================
interface plcp_frame_parser_if;
  logic        In_Bit;
  logic        In_Valid;
  logic        Abort;
  logic        Out_Bit;
  logic        Out_Valid;
  logic        Out_Start;
  logic        Out_End;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic        Header_Valid;
  logic        Error;
  logic [2:0]  Error_Code;
  logic        Busy;

  modport master (
    output In_Bit, In_Valid, Abort,
    input  Out_Bit, Out_Valid, Out_Start, Out_End, Rate, Length,
           Header_Valid, Error, Error_Code, Busy
  );

  modport slave (
    input  In_Bit, In_Valid, Abort,
    output Out_Bit, Out_Valid, Out_Start, Out_End, Rate, Length,
           Header_Valid, Error, Error_Code, Busy
  );
endinterface
`default_nettype wire

// File: rtl/plcp_frame_parser.sv
`default_nettype none
//==============================================================================
// Module : plcp_frame_parser
// Bit-serial 802.11a PLCP parser: preamble hunt, SIGNAL check, descrambled PSDU.
// Rev    : 1.0
//==============================================================================
module plcp_frame_parser #(
  parameter int                      PREAMBLE_LEN     = 96,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_PATTERN = {12{8'hAA}},
  parameter int                      MAX_MISMATCH     = 0,
  parameter bit                      CHECK_SERVICE    = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  plcp_frame_parser_if.slave bus
);
  localparam int                POP_W  = $clog2(PREAMBLE_LEN + 1);
  localparam logic [POP_W-1:0]  MAX_MM = POP_W'(MAX_MISMATCH);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_SIGNAL  = 3'd1;
  localparam logic [2:0] S_SERVICE = 3'd2;
  localparam logic [2:0] S_PSDU    = 3'd3;
  localparam logic [2:0] S_TAIL    = 3'd4;
  localparam logic [2:0] S_PAD     = 3'd5;

  function automatic logic [7:0] rate_ndbps(input logic [3:0] r);
    case (r)
      4'b1101: rate_ndbps = 8'd24;
      4'b1111: rate_ndbps = 8'd36;
      4'b0101: rate_ndbps = 8'd48;
      4'b0111: rate_ndbps = 8'd72;
      4'b1001: rate_ndbps = 8'd96;
      4'b1011: rate_ndbps = 8'd144;
      4'b0001: rate_ndbps = 8'd192;
      4'b0011: rate_ndbps = 8'd216;
      default: rate_ndbps = 8'd0;
    endcase
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [PREAMBLE_LEN-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < PREAMBLE_LEN; i++) c = c + {{(POP_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  logic [2:0]              state_q, state_d;
  logic [PREAMBLE_LEN-1:0] win_q, win_d;
  logic [14:0]             cnt_q, cnt_d;
  logic [22:0]             sig_q, sig_d;
  logic [6:0]              lfsr_q, lfsr_d;
  logic [7:0]              sym_q, sym_d;
  logic [7:0]              ndbps_q, ndbps_d;
  logic [3:0]              rate_q, rate_d;
  logic [11:0]             length_q, length_d;
  logic                    out_bit_q, out_bit_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_start_q, out_start_d;
  logic                    out_end_q, out_end_d;
  logic                    hdr_q, hdr_d;
  logic                    err_q, err_d;
  logic [2:0]              code_q, code_d;

  logic [PREAMBLE_LEN-1:0] w_win;
  logic [POP_W-1:0]        w_pop;
  logic [23:0]             w_sig;
  logic [3:0]              w_sig_rate;
  logic [11:0]             w_sig_len;
  logic [7:0]              w_sig_ndbps;
  logic [2:0]              w_sig_code;
  logic                    w_fb;
  logic                    w_desc;
  logic [7:0]              w_sym_next;
  logic [14:0]             w_psdu_last;

  assign w_win       = {win_q[PREAMBLE_LEN-2:0], bus.In_Bit};
  assign w_pop       = popcount(w_win ^ PREAMBLE_PATTERN);
  assign w_sig       = {bus.In_Bit, sig_q};
  assign w_sig_rate  = {w_sig[0], w_sig[1], w_sig[2], w_sig[3]};
  assign w_sig_len   = w_sig[16:5];
  assign w_sig_ndbps = rate_ndbps(w_sig_rate);
  // Scrambler x^7 + x^4 + 1: lfsr_q[6] is s7, lfsr_q[3] is s4.
  assign w_fb        = lfsr_q[6] ^ lfsr_q[3];
  assign w_desc      = bus.In_Bit ^ w_fb;
  assign w_sym_next  = (sym_q == ndbps_q - 8'd1) ? 8'd0 : sym_q + 8'd1;
  assign w_psdu_last = {length_q, 3'b000} - 15'd1;

  always_comb begin
    w_sig_code = 3'd0;
    if (^w_sig[17:0])             w_sig_code = 3'd1;
    else if (w_sig_ndbps == 8'd0) w_sig_code = 3'd2;
    else if (w_sig[4])            w_sig_code = 3'd3;
    else if (|w_sig[23:18])       w_sig_code = 3'd4;
    else if (w_sig_len == 12'd0)  w_sig_code = 3'd6;
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    lfsr_d      = lfsr_q;
    sym_d       = sym_q;
    ndbps_d     = ndbps_q;
    rate_d      = rate_q;
    length_d    = length_q;
    code_d      = code_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_end_d   = 1'b0;
    hdr_d       = 1'b0;
    err_d       = 1'b0;
    if (bus.Abort) begin
      state_d = S_HUNT;
      win_d   = '0;
      cnt_d   = '0;
    end else if (bus.In_Valid) begin
      case (state_q)
        S_HUNT: begin
          win_d = w_win;
          if (w_pop <= MAX_MM) begin
            state_d = S_SIGNAL;
            win_d   = '0;
            cnt_d   = '0;
          end
        end
        S_SIGNAL: begin
          sig_d = w_sig[23:1];
          cnt_d = cnt_q + 15'd1;
          if (cnt_q == 15'd23) begin
            cnt_d = '0;
            if (w_sig_code != 3'd0) begin
              err_d   = 1'b1;
              code_d  = w_sig_code;
              state_d = S_HUNT;
            end else begin
              hdr_d    = 1'b1;
              rate_d   = w_sig_rate;
              length_d = w_sig_len;
              ndbps_d  = w_sig_ndbps;
              sym_d    = '0;
              state_d  = S_SERVICE;
            end
          end
        end
        S_SERVICE: begin
          sym_d = w_sym_next;
          cnt_d = cnt_q + 15'd1;
          // First seven SERVICE bits are scrambled zeros, i.e. the raw seed.
          if (cnt_q < 15'd7) begin
            lfsr_d = {lfsr_q[5:0], bus.In_Bit};
          end else begin
            lfsr_d = {lfsr_q[5:0], w_fb};
          end
          if (cnt_q >= 15'd7 && CHECK_SERVICE && w_desc) begin
            err_d   = 1'b1;
            code_d  = 3'd5;
            cnt_d   = '0;
            state_d = S_HUNT;
          end else if (cnt_q == 15'd15) begin
            cnt_d   = '0;
            state_d = S_PSDU;
          end
        end
        S_PSDU: begin
          sym_d       = w_sym_next;
          lfsr_d      = {lfsr_q[5:0], w_fb};
          out_bit_d   = w_desc;
          out_valid_d = 1'b1;
          out_start_d = (cnt_q == 15'd0);
          out_end_d   = (cnt_q == w_psdu_last);
          cnt_d       = cnt_q + 15'd1;
          if (cnt_q == w_psdu_last) begin
            cnt_d   = '0;
            state_d = S_TAIL;
          end
        end
        S_TAIL: begin
          sym_d = w_sym_next;
          cnt_d = cnt_q + 15'd1;
          if (cnt_q == 15'd5) begin
            cnt_d   = '0;
            state_d = (w_sym_next == 8'd0) ? S_HUNT : S_PAD;
          end
        end
        S_PAD: begin
          sym_d = w_sym_next;
          if (w_sym_next == 8'd0) state_d = S_HUNT;
        end
        default: begin
          state_d = S_HUNT;
          win_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= S_HUNT;
      win_q       <= '0;
      cnt_q       <= '0;
      sig_q       <= '0;
      lfsr_q      <= '0;
      sym_q       <= '0;
      ndbps_q     <= 8'd24;
      rate_q      <= 4'b1101;
      length_q    <= '0;
      code_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      hdr_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      lfsr_q      <= lfsr_d;
      sym_q       <= sym_d;
      ndbps_q     <= ndbps_d;
      rate_q      <= rate_d;
      length_q    <= length_d;
      code_q      <= code_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      hdr_q       <= hdr_d;
      err_q       <= err_d;
    end
  end

  assign bus.Out_Bit      = out_bit_q;
  assign bus.Out_Valid    = out_valid_q;
  assign bus.Out_Start    = out_start_q;
  assign bus.Out_End      = out_end_q;
  assign bus.Rate         = rate_q;
  assign bus.Length       = length_q;
  assign bus.Header_Valid = hdr_q;
  assign bus.Error        = err_q;
  assign bus.Error_Code   = code_q;
  assign bus.Busy         = (state_q != S_HUNT);
endmodule
`default_nettype wire

// File: tb/tb_plcp_frame_parser.sv
`default_nettype none
//==============================================================================
// Module : tb_plcp_frame_parser
// Directed bench; three parser instances share one input stream.
// Rev    : 1.0
//==============================================================================
module tb_plcp_frame_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  plcp_frame_parser_if if0 ();
  plcp_frame_parser_if if1 ();
  plcp_frame_parser_if if2 ();

  assign if0.In_Bit = in_bit;  assign if0.In_Valid = in_valid;  assign if0.Abort = abort;
  assign if1.In_Bit = in_bit;  assign if1.In_Valid = in_valid;  assign if1.Abort = abort;
  assign if2.In_Bit = in_bit;  assign if2.In_Valid = in_valid;  assign if2.Abort = abort;

  // dut0: defaults; dut1: preamble tolerance 2; dut2: SERVICE check disabled.
  plcp_frame_parser dut0 (.Clock(clk), .Reset(rst_n), .bus(if0));
  plcp_frame_parser #(.MAX_MISMATCH(2)) dut1 (.Clock(clk), .Reset(rst_n), .bus(if1));
  plcp_frame_parser #(.CHECK_SERVICE(1'b0)) dut2 (.Clock(clk), .Reset(rst_n), .bus(if2));

  int vectors = 0;
  int miscompares = 0;

  logic rx0[$];
  logic rx2[$];
  int hv0 = 0, er0 = 0, ls0 = -1, le0 = -1;
  int hv2 = 0, er2 = 0;

  always @(negedge clk) begin
    if (if0.Out_Valid) begin
      if (if0.Out_Start) ls0 = rx0.size();
      if (if0.Out_End) le0 = rx0.size();
      rx0.push_back(if0.Out_Bit);
    end
    if (if0.Header_Valid) hv0++;
    if (if0.Error) er0++;
    if (if2.Out_Valid) rx2.push_back(if2.Out_Bit);
    if (if2.Header_Valid) hv2++;
    if (if2.Error) er2++;
  end

  logic tx[$];
  logic exp_psdu[$];

  function automatic int ndbps_of(input logic [3:0] r);
    case (r)
      4'b1101: return 24;   4'b1111: return 36;
      4'b0101: return 48;   4'b0111: return 72;
      4'b1001: return 96;   4'b1011: return 144;
      4'b0001: return 192;  4'b0011: return 216;
      default: return 24;
    endcase
  endfunction

  function automatic int count_bad(input logic q[$], input int base);
    int n = 0;
    for (int i = 0; i < exp_psdu.size(); i++)
      if (base + i >= q.size() || q[base + i] !== exp_psdu[i]) n++;
    return n;
  endfunction

  // Transmit-side frame model: preamble, SIGNAL, scrambled SERVICE/PSDU/tail, pad.
  task automatic build(input logic [3:0] rate, input int len, input bit flip_par,
                       input bit rsv, input logic [5:0] tail, input int svc_err,
                       input int n_flips);
    logic [95:0] pre;
    logic [23:0] s;
    logic [11:0] l12;
    logic [6:0]  st;
    logic [7:0]  v;
    logic        d, fb, b;
    int          total, nd, pad;
    tx.delete();
    exp_psdu.delete();
    pre = {12{8'hAA}};
    for (int i = 0; i < 96; i++) begin
      b = pre[95 - i];
      if (i < n_flips) b = ~b;
      tx.push_back(b);
    end
    l12 = 12'(len);
    s = '0;
    s[0] = rate[3]; s[1] = rate[2]; s[2] = rate[1]; s[3] = rate[0];
    s[4] = rsv;
    for (int k = 0; k < 12; k++) s[5 + k] = l12[k];
    s[17] = (^s[16:0]) ^ flip_par;
    s[23:18] = tail;
    for (int i = 0; i < 24; i++) tx.push_back(s[i]);
    st = 7'b1011101;
    total = 22 + 8 * len;
    for (int j = 0; j < total; j++) begin
      d = (j == svc_err);
      if (j >= 16 && j < 16 + 8 * len) begin
        v = 8'((j - 16) / 8 * 59 + 90);
        d = v[(j - 16) % 8];
        exp_psdu.push_back(d);
      end
      fb = st[6] ^ st[3];
      tx.push_back(d ^ fb);
      st = {st[5:0], fb};
    end
    nd = ndbps_of(rate);
    pad = (nd - total % nd) % nd;
    for (int j = 0; j < pad; j++) tx.push_back(1'b0);
  endtask

  task automatic send_bit(input logic b);
    in_bit = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) send_bit(tx[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    vectors++; if (if0.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", if0.Out_Valid); end
    vectors++; if (if0.Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", if0.Busy); end
    vectors++; if (if0.Rate !== 4'b1101) begin miscompares++; $display("FAIL rst_rate: got %b want 1101", if0.Rate); end
    vectors++; if (if0.Length !== 12'd0) begin miscompares++; $display("FAIL rst_length: got %0d want 0", if0.Length); end
    vectors++; if ({if0.Header_Valid, if0.Error, if0.Error_Code} !== 5'd0) begin miscompares++; $display("FAIL rst_status: got %b want 00000", {if0.Header_Valid, if0.Error, if0.Error_Code}); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    int base, h, e, bad;
    build(4'b1101, 16, 1'b0, 1'b0, 6'd0, -1, 0);
    base = rx0.size(); h = hv0; e = er0;
    for (int i = 0; i < tx.size(); i++) begin
      send_bit(tx[i]);
      if (i == 94) begin vectors++; if (if0.Busy !== 1'b0) begin miscompares++; $display("FAIL det_early: got %0b want 0", if0.Busy); end end
      if (i == 95) begin vectors++; if (if0.Busy !== 1'b1) begin miscompares++; $display("FAIL det: got %0b want 1", if0.Busy); end end
      if (i == 119) begin vectors++; if (if0.Header_Valid !== 1'b1) begin miscompares++; $display("FAIL hdr_pulse: got %0b want 1", if0.Header_Valid); end end
      if (i == tx.size() - 2) begin vectors++; if (if0.Busy !== 1'b1) begin miscompares++; $display("FAIL pad_busy: got %0b want 1", if0.Busy); end end
    end
    vectors++; if (if0.Busy !== 1'b0) begin miscompares++; $display("FAIL pad_done: got %0b want 0", if0.Busy); end
    idle(2);
    vectors++; if (hv0 - h !== 1) begin miscompares++; $display("FAIL basic_hdr_count: got %0d want 1", hv0 - h); end
    vectors++; if (if0.Rate !== 4'b1101) begin miscompares++; $display("FAIL basic_rate: got %b want 1101", if0.Rate); end
    vectors++; if (if0.Length !== 12'd16) begin miscompares++; $display("FAIL basic_length: got %0d want 16", if0.Length); end
    vectors++; if (rx0.size() - base !== 128) begin miscompares++; $display("FAIL basic_nbits: got %0d want 128", rx0.size() - base); end
    bad = count_bad(rx0, base);
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL basic_data: got %0d wrong bits want 0", bad); end
    vectors++; if (ls0 !== base) begin miscompares++; $display("FAIL basic_start: got %0d want %0d", ls0, base); end
    vectors++; if (le0 !== base + 127) begin miscompares++; $display("FAIL basic_end: got %0d want %0d", le0, base + 127); end
    vectors++; if (er0 !== e) begin miscompares++; $display("FAIL basic_err: got %0d want %0d", er0, e); end
  endtask

  task automatic test_gaps();
    int base, h, bad;
    build(4'b0011, 1, 1'b0, 1'b0, 6'd0, -1, 0);
    base = rx0.size(); h = hv0;
    for (int i = 0; i < tx.size(); i++) begin
      send_bit(tx[i]);
      idle(1);
      if (i == tx.size() - 2) begin vectors++; if (if0.Busy !== 1'b1) begin miscompares++; $display("FAIL gap_pad_busy: got %0b want 1", if0.Busy); end end
    end
    vectors++; if (if0.Busy !== 1'b0) begin miscompares++; $display("FAIL gap_pad_done: got %0b want 0", if0.Busy); end
    idle(1);
    vectors++; if (rx0.size() - base !== 8) begin miscompares++; $display("FAIL gap_nbits: got %0d want 8", rx0.size() - base); end
    bad = count_bad(rx0, base);
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL gap_data: got %0d wrong bits want 0", bad); end
    vectors++; if (ls0 !== base || le0 !== base + 7) begin miscompares++; $display("FAIL gap_framing: got start %0d end %0d want %0d %0d", ls0, le0, base, base + 7); end
    vectors++; if (if0.Rate !== 4'b0011 || if0.Length !== 12'd1) begin miscompares++; $display("FAIL gap_header: got %b/%0d want 0011/1", if0.Rate, if0.Length); end
    build(4'b1011, 3, 1'b0, 1'b0, 6'd0, -1, 0);
    base = rx0.size();
    send_range(0, tx.size());
    idle(2);
    vectors++; if (hv0 - h !== 2) begin miscompares++; $display("FAIL next_hdr_count: got %0d want 2", hv0 - h); end
    vectors++; if (if0.Rate !== 4'b1011 || if0.Length !== 12'd3) begin miscompares++; $display("FAIL next_header: got %b/%0d want 1011/3", if0.Rate, if0.Length); end
    bad = count_bad(rx0, base);
    vectors++; if (rx0.size() - base !== 24 || bad !== 0) begin miscompares++; $display("FAIL next_data: got %0d bits %0d wrong want 24 0", rx0.size() - base, bad); end
    vectors++; if (if0.Busy !== 1'b0) begin miscompares++; $display("FAIL next_idle: got %0b want 0", if0.Busy); end
  endtask

  task automatic test_signal_errors();
    logic [3:0] rates[5] = '{4'b1101, 4'b0000, 4'b1101, 4'b1101, 4'b1101};
    int         lens[5]  = '{16, 16, 16, 16, 0};
    logic [2:0] codes[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    int base, h;
    base = rx0.size(); h = hv0;
    for (int k = 0; k < 5; k++) begin
      build(rates[k], lens[k], k == 0, k == 2, (k == 3) ? 6'b000100 : 6'd0, -1, 0);
      send_range(0, 120);
      vectors++; if (if0.Error !== 1'b1 || if0.Error_Code !== codes[k]) begin miscompares++; $display("FAIL sig_err_%0d: got err %0b code %0d want 1 %0d", k, if0.Error, if0.Error_Code, codes[k]); end
      idle(3);
      vectors++; if (if0.Error !== 1'b0 || if0.Error_Code !== codes[k] || if0.Busy !== 1'b0) begin miscompares++; $display("FAIL sig_hold_%0d: got err %0b code %0d busy %0b want 0 %0d 0", k, if0.Error, if0.Error_Code, if0.Busy, codes[k]); end
    end
    vectors++; if (hv0 !== h || rx0.size() !== base) begin miscompares++; $display("FAIL sig_no_output: got hdr %0d bits %0d want 0 0", hv0 - h, rx0.size() - base); end
  endtask

  task automatic test_mismatch();
    do_reset();
    build(4'b1101, 16, 1'b0, 1'b0, 6'd0, -1, 2);
    for (int i = 0; i < 96; i++) begin
      send_bit(tx[i]);
      if (i == 94) begin vectors++; if (if1.Busy !== 1'b0) begin miscompares++; $display("FAIL mm2_early: got %0b want 0", if1.Busy); end end
    end
    vectors++; if (if1.Busy !== 1'b1) begin miscompares++; $display("FAIL mm2_detect: got %0b want 1", if1.Busy); end
    vectors++; if (if0.Busy !== 1'b0) begin miscompares++; $display("FAIL mm0_reject: got %0b want 0", if0.Busy); end
    do_reset();
    build(4'b1101, 16, 1'b0, 1'b0, 6'd0, -1, 3);
    send_range(0, 96);
    idle(2);
    vectors++; if (if1.Busy !== 1'b0) begin miscompares++; $display("FAIL mm3_reject: got %0b want 0", if1.Busy); end
  endtask

  task automatic test_reset_midframe();
    int base, bad;
    do_reset();
    build(4'b0101, 16, 1'b0, 1'b0, 6'd0, -1, 0);
    base = rx0.size();
    send_range(0, 176);
    vectors++; if (if0.Out_Valid !== 1'b1 || if0.Rate !== 4'b0101) begin miscompares++; $display("FAIL mid_active: got valid %0b rate %b want 1 0101", if0.Out_Valid, if0.Rate); end
    in_bit = tx[176]; in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (if0.Out_Valid !== 1'b0 || if0.Busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_idle: got valid %0b busy %0b want 0 0", if0.Out_Valid, if0.Busy); end
    vectors++; if (if0.Rate !== 4'b1101 || if0.Length !== 12'd0 || if0.Error_Code !== 3'd0) begin miscompares++; $display("FAIL mid_rst_regs: got %b/%0d/%0d want 1101/0/0", if0.Rate, if0.Length, if0.Error_Code); end
    rst_n = 1'b1;
    idle(1);
    build(4'b0111, 2, 1'b0, 1'b0, 6'd0, -1, 0);
    base = rx0.size();
    send_range(0, tx.size());
    idle(2);
    bad = count_bad(rx0, base);
    vectors++; if (rx0.size() - base !== 16 || bad !== 0) begin miscompares++; $display("FAIL mid_new_frame: got %0d bits %0d wrong want 16 0", rx0.size() - base, bad); end
    vectors++; if (if0.Rate !== 4'b0111 || if0.Length !== 12'd2 || if0.Busy !== 1'b0) begin miscompares++; $display("FAIL mid_new_hdr: got %b/%0d busy %0b want 0111/2 0", if0.Rate, if0.Length, if0.Busy); end
  endtask

  task automatic test_abort();
    int e, h, base;
    e = er0; h = hv0;
    build(4'b1101, 16, 1'b0, 1'b0, 6'd0, -1, 0);
    send_range(0, 125);
    vectors++; if (if0.Busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre: got %0b want 1", if0.Busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++; if (if0.Busy !== 1'b0 || if0.Error !== 1'b0) begin miscompares++; $display("FAIL abort_hunt: got busy %0b err %0b want 0 0", if0.Busy, if0.Error); end
    idle(2);
    base = rx0.size();
    send_range(0, tx.size());
    idle(2);
    vectors++; if (er0 !== e || hv0 - h !== 2 || rx0.size() - base !== 128) begin miscompares++; $display("FAIL abort_after: got err %0d hdr %0d bits %0d want 0 2 128", er0 - e, hv0 - h, rx0.size() - base); end
  endtask

  task automatic test_service();
    int base0, base2, h2, e2, bad;
    do_reset();
    build(4'b1101, 4, 1'b0, 1'b0, 6'd0, 10, 0);
    base0 = rx0.size(); base2 = rx2.size(); h2 = hv2; e2 = er2;
    send_range(0, 130);
    vectors++; if (if0.Error !== 1'b0) begin miscompares++; $display("FAIL svc_before: got %0b want 0", if0.Error); end
    send_bit(tx[130]);
    vectors++; if (if0.Error !== 1'b1 || if0.Error_Code !== 3'd5 || if0.Busy !== 1'b0) begin miscompares++; $display("FAIL svc_err: got err %0b code %0d busy %0b want 1 5 0", if0.Error, if0.Error_Code, if0.Busy); end
    vectors++; if (if2.Error !== 1'b0 || if2.Busy !== 1'b1) begin miscompares++; $display("FAIL svc_nocheck_live: got err %0b busy %0b want 0 1", if2.Error, if2.Busy); end
    send_range(131, tx.size());
    idle(2);
    bad = count_bad(rx2, base2);
    vectors++; if (hv2 - h2 !== 1 || er2 !== e2 || rx2.size() - base2 !== 32 || bad !== 0) begin miscompares++; $display("FAIL svc_nocheck_frame: got hdr %0d err %0d bits %0d wrong %0d want 1 0 32 0", hv2 - h2, er2 - e2, rx2.size() - base2, bad); end
    vectors++; if (rx0.size() !== base0) begin miscompares++; $display("FAIL svc_no_output: got %0d bits want 0", rx0.size() - base0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_signal_errors();
    test_mismatch();
    test_reset_midframe();
    test_abort();
    test_service();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
